// File: rtl/state_sequencer.sv
// Multicycle CPU state register with a memory-ready stall handshake, a stall
// watchdog, a sticky halt state and cycle / retired-instruction counters.
module state_sequencer #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter logic [3:0] HALT_STATE  = 4'd15,
  parameter int         STALL_LIMIT = 16,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       next_state,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             mem_req,
  output logic             stall,
  output logic             state_entry,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

  logic [SW-1:0]    stall_cnt, stall_cnt_d;
  logic [3:0]       state_d;
  logic             entry_d, timeout_d;
  logic [CNT_W-1:0] cycle_d, instr_d;
  logic             is_mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RESET_STATE;
      state_entry <= 1'b1;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_d;
      state_entry <= entry_d;
      stall_cnt   <= stall_cnt_d;
      mem_timeout <= timeout_d;
      cycle_count <= cycle_d;
      instr_count <= instr_d;
    end
  end

  // Watchdog outranks the plain stall, which outranks a normal transition.
  // A forced halt is not a retire, so instr_count is only touched on the accept path.
  always_comb begin
    state_d     = state;
    entry_d     = 1'b0;
    stall_cnt_d = stall_cnt;
    timeout_d   = mem_timeout;
    cycle_d     = cycle_count;
    instr_d     = instr_count;
    if (!halted) begin
      cycle_d = cycle_count + CNT_W'(1);
      if (is_mem && !mem_ready) begin
        if (stall_cnt == STALL_LAST) begin
          state_d     = HALT_STATE;
          timeout_d   = 1'b1;
          stall_cnt_d = '0;
          entry_d     = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt + SW'(1);
        end
      end else begin
        state_d     = next_state;
        stall_cnt_d = '0;
        entry_d     = 1'b1;
        if ((state != 4'd0 && next_state == 4'd0) ||
            (state == 4'd14 && next_state == HALT_STATE)) begin
          instr_d = instr_count + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    is_mem  = (state == 4'd0) || (state == 4'd9) || (state == 4'd10);
    halted  = (state == HALT_STATE);
    mem_req = is_mem && !halted;
    stall   = is_mem && !mem_ready && !halted;
  end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed and randomized bench for state_sequencer, checked against a
// behavioural model of the sequencing rules kept in plain integers.
module tb_state_sequencer;

  localparam int STALL_LIMIT = 16;
  localparam int CNT_W       = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       next_state;
  logic             mem_ready;
  logic [3:0]       state;
  logic             mem_req, stall, state_entry, halted, mem_timeout;
  logic [CNT_W-1:0] cycle_count, instr_count;

  int total = 0;
  int bad   = 0;

  int          m_state;
  int          m_stall;
  bit          m_timeout;
  bit          m_entry;
  int unsigned m_cycles;
  int unsigned m_instr;

  state_sequencer #(
    .RESET_STATE(4'd0),
    .HALT_STATE (4'd15),
    .STALL_LIMIT(STALL_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .next_state (next_state),
    .mem_ready  (mem_ready),
    .state      (state),
    .mem_req    (mem_req),
    .stall      (stall),
    .state_entry(state_entry),
    .halted     (halted),
    .mem_timeout(mem_timeout),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic bit is_mem_state(int s);
    return (s == 0) || (s == 9) || (s == 10);
  endfunction

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_stall   = 0;
    m_timeout = 1'b0;
    m_entry   = 1'b1;
    m_cycles  = 0;
    m_instr   = 0;
  endtask

  task automatic check_all(string tag);
    check_output({tag, ".state"},  32'(state),       32'(m_state));
    check_output({tag, ".entry"},  32'(state_entry), 32'(m_entry));
    check_output({tag, ".halted"}, 32'(halted),      32'(m_state == 15));
    check_output({tag, ".tmo"},    32'(mem_timeout), 32'(m_timeout));
    check_output({tag, ".cycles"}, cycle_count,      m_cycles);
    check_output({tag, ".instr"},  instr_count,      m_instr);
  endtask

  // Drive one cycle: check the combinational handshake, clock, then check state.
  task automatic apply_stimulus(string tag, logic [3:0] ns, logic rdy);
    bit live;
    next_state = ns;
    mem_ready  = rdy;
    #1;
    live = (m_state != 15);
    check_output({tag, ".mem_req"}, 32'(mem_req), 32'(live && is_mem_state(m_state)));
    check_output({tag, ".stall"},   32'(stall),   32'(live && is_mem_state(m_state) && !rdy));
    @(posedge clk);
    if (live) begin
      m_cycles++;
      if (is_mem_state(m_state) && !rdy) begin
        if (m_stall == STALL_LIMIT - 1) begin
          m_state   = 15;
          m_timeout = 1'b1;
          m_stall   = 0;
          m_entry   = 1'b1;
        end else begin
          m_stall++;
          m_entry = 1'b0;
        end
      end else begin
        if ((m_state != 0 && ns == 0) || (m_state == 14 && ns == 15)) m_instr++;
        m_state = ns;
        m_stall = 0;
        m_entry = 1'b1;
      end
    end else begin
      m_entry = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int halt_run;
    next_state = 4'd0;
    mem_ready  = 1'b1;
    reset      = 1'b1;
    #3;
    reset_dut();

    // R-type instruction 0->1->2->8->0
    apply_stimulus("rtype0", 4'd1, 1'b1);
    apply_stimulus("rtype1", 4'd2, 1'b1);
    apply_stimulus("rtype2", 4'd8, 1'b1);
    apply_stimulus("rtype3", 4'd0, 1'b1);
    check_output("rtype.instr_lit",  instr_count, 32'd1);
    check_output("rtype.cycles_lit", cycle_count, 32'd4);

    // Fetch stall for three cycles, then advance
    for (int i = 0; i < 3; i++) apply_stimulus("fstall", 4'd1, 1'b0);
    check_output("fstall.state_lit", 32'(state), 32'd0);
    apply_stimulus("fgo", 4'd1, 1'b1);
    check_output("fgo.state_lit",  32'(state),  32'd1);
    check_output("fgo.cycles_lit", cycle_count, 32'd8);

    // Load that never completes trips the watchdog
    apply_stimulus("ld0", 4'd3, 1'b1);
    apply_stimulus("ld1", 4'd9, 1'b1);
    for (int i = 0; i < STALL_LIMIT; i++) apply_stimulus("ldwait", 4'd4, 1'b0);
    check_output("tmo.state_lit", 32'(state),       32'd15);
    check_output("tmo.flag_lit",  32'(mem_timeout), 32'd1);
    check_output("tmo.instr_lit", instr_count,      32'd1);
    for (int i = 0; i < 10; i++) apply_stimulus("frozen", 4'(i), 1'(i % 2));
    check_output("frozen.cycles_lit", cycle_count, 32'd26);

    // Ecall retire into halt
    reset_dut();
    apply_stimulus("ec0", 4'd1, 1'b1);
    apply_stimulus("ec1", 4'd14, 1'b0);
    apply_stimulus("ec2", 4'd15, 1'b0);
    check_output("ecall.instr_lit", instr_count, 32'd1);
    check_output("ecall.tmo_lit",   32'(mem_timeout), 32'd0);
    for (int i = 0; i < 4; i++) apply_stimulus("ecstay", 4'd0, 1'(i % 2));
    check_output("ecstay.state_lit", 32'(state), 32'd15);

    // Asynchronous reset in the middle of a store stall
    reset_dut();
    apply_stimulus("st0", 4'd1, 1'b1);
    apply_stimulus("st1", 4'd3, 1'b1);
    apply_stimulus("st2", 4'd10, 1'b1);
    for (int i = 0; i < 7; i++) apply_stimulus("ststall", 4'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_output("async.state_lit",  32'(state),       32'd0);
    check_output("async.cycles_lit", cycle_count,      32'd0);
    check_output("async.tmo_lit",    32'(mem_timeout), 32'd0);
    check_all("async");
    @(negedge clk);
    reset = 1'b1;

    // One stall short of the limit never times out, and the count restarts
    apply_stimulus("b0", 4'd1, 1'b1);
    apply_stimulus("b1", 4'd3, 1'b1);
    apply_stimulus("b2", 4'd9, 1'b1);
    for (int i = 0; i < STALL_LIMIT - 1; i++) apply_stimulus("bwait", 4'd5, 1'b0);
    apply_stimulus("bgo", 4'd12, 1'b1);
    check_output("bound.state_lit", 32'(state),       32'd12);
    check_output("bound.tmo_lit",   32'(mem_timeout), 32'd0);
    apply_stimulus("b3", 4'd0, 1'b1);
    for (int i = 0; i < STALL_LIMIT - 1; i++) apply_stimulus("bwait2", 4'd1, 1'b0);
    apply_stimulus("bgo2", 4'd1, 1'b1);
    check_output("bound2.tmo_lit", 32'(mem_timeout), 32'd0);

    // Randomized traffic, recovering from halts with a reset
    halt_run = 0;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ns;
      logic       rdy;
      ns  = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      if (i >= 200 && i < 230) rdy = 1'b0;
      apply_stimulus("rand", ns, rdy);
      if (m_state == 15) halt_run++;
      if (halt_run > 3) begin
        halt_run = 0;
        reset_dut();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
